// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with register file, immediate generation, load-use hazard detection and ID/EX register.
// Optional WB_BYPASS_EN: write-first bypass of write-back data onto the read ports.
module id_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int NREG       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           ID_pc_i,
  input  logic [31:0]           ID_instr_i,
  input  logic                  flush,
  input  logic                  WB_we_i,
  input  logic [4:0]            WB_rd_i,
  input  logic [DATA_WIDTH-1:0] WB_data_i,
  output logic                  stall,
  output logic [31:0]           EX_pc_o,
  output logic [DATA_WIDTH-1:0] EX_rs1_data_o,
  output logic [DATA_WIDTH-1:0] EX_rs2_data_o,
  output logic [31:0]           EX_imm_o,
  output logic [4:0]            EX_rs1_o,
  output logic [4:0]            EX_rs2_o,
  output logic [4:0]            EX_rd_o,
  output logic [2:0]            EX_funct3_o,
  output logic [3:0]            EX_alu_op_o,
  output logic                  EX_alu_src_o,
  output logic                  EX_pc_src_a_o,
  output logic                  EX_memread_o,
  output logic                  EX_memwrite_o,
  output logic                  EX_regwrite_o,
  output logic                  EX_mem2reg_o,
  output logic                  EX_branch_o,
  output logic                  EX_jump_o
);
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       pc_src_a;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       mem2reg;
    logic       branch;
    logic       jump;
  } ctrl_t;

  logic [DATA_WIDTH-1:0] rf_q [NREG];
  logic [31:0] instr, imm_d, imm_q, pc_q;
  logic [6:0] opc;
  logic [2:0] f3, f3_q;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic rs1_used, rs2_used, hazard, kill;
  logic [4:0] rs1_idx, rs2_idx, rd_d, rd_q, rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0] rs1_data, rs2_data, rs1_data_q, rs2_data_q;
  ctrl_t ctrl_d, ctrl_q;

  assign instr    = ID_instr_i;
  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign is_r     = opc == 7'b0110011;
  assign is_i     = opc == 7'b0010011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_br    = opc == 7'b1100011;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;

  always_comb begin
    ctrl_d          = '0;
    ctrl_d.alu_op   = is_r ? {instr[30], f3} :
                      is_i ? {(f3 == 3'b101) & instr[30], f3} :
                      is_br ? 4'b1000 : 4'b0000;
    ctrl_d.alu_src  = is_i | is_ld | is_st | is_jalr | is_lui | is_auipc;
    ctrl_d.pc_src_a = is_jal | is_auipc;
    ctrl_d.memread  = is_ld;
    ctrl_d.memwrite = is_st;
    ctrl_d.regwrite = is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_auipc;
    ctrl_d.mem2reg  = is_ld;
    ctrl_d.branch   = is_br;
    ctrl_d.jump     = is_jal | is_jalr;
  end

  assign rd_d = ctrl_d.regwrite ? instr[11:7] : 5'd0;

  assign imm_d = is_st ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                 is_br ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                 (is_lui | is_auipc) ? {instr[31:12], 12'b0} :
                 is_jal ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
                 {{20{instr[31]}}, instr[31:20]};

  assign rs1_idx = is_lui ? 5'd0 : instr[19:15];
  assign rs2_idx = instr[24:20];

`ifdef WB_BYPASS_EN
  assign rs1_data = (rs1_idx == 5'd0) ? '0 : (WB_we_i && WB_rd_i == rs1_idx) ? WB_data_i : rf_q[rs1_idx];
  assign rs2_data = (rs2_idx == 5'd0) ? '0 : (WB_we_i && WB_rd_i == rs2_idx) ? WB_data_i : rf_q[rs2_idx];
`else
  assign rs1_data = (rs1_idx == 5'd0) ? '0 : rf_q[rs1_idx];
  assign rs2_data = (rs2_idx == 5'd0) ? '0 : rf_q[rs2_idx];
`endif

  assign rs1_used = is_r | is_i | is_ld | is_st | is_br | is_jalr;
  assign rs2_used = is_r | is_st | is_br;
  assign hazard   = ctrl_q.memread && rd_q != 5'd0 &&
                    ((rd_q == instr[19:15] && rs1_used) || (rd_q == instr[24:20] && rs2_used));
  // flush squashes the stall; reset holds it low so fetch never sees a stale hazard
  assign stall = rst_n & ~flush & hazard;
  assign kill  = flush | stall;

  always_ff @(posedge clk) begin
    if (!rst_n)
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    else if (WB_we_i && WB_rd_i != 5'd0)
      rf_q[WB_rd_i] <= WB_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      f3_q       <= '0;
      ctrl_q     <= '0;
    end else begin
      pc_q       <= ID_pc_i;
      rs1_data_q <= rs1_data;
      rs2_data_q <= rs2_data;
      imm_q      <= imm_d;
      rs1_q      <= rs1_idx;
      rs2_q      <= rs2_idx;
      f3_q       <= f3;
      rd_q       <= kill ? 5'd0 : rd_d;
      ctrl_q     <= kill ? '0 : ctrl_d;
    end
  end

  assign EX_pc_o       = pc_q;
  assign EX_rs1_data_o = rs1_data_q;
  assign EX_rs2_data_o = rs2_data_q;
  assign EX_imm_o      = imm_q;
  assign EX_rs1_o      = rs1_q;
  assign EX_rs2_o      = rs2_q;
  assign EX_rd_o       = rd_q;
  assign EX_funct3_o   = f3_q;
  assign EX_alu_op_o   = ctrl_q.alu_op;
  assign EX_alu_src_o  = ctrl_q.alu_src;
  assign EX_pc_src_a_o = ctrl_q.pc_src_a;
  assign EX_memread_o  = ctrl_q.memread;
  assign EX_memwrite_o = ctrl_q.memwrite;
  assign EX_regwrite_o = ctrl_q.regwrite;
  assign EX_mem2reg_o  = ctrl_q.mem2reg;
  assign EX_branch_o   = ctrl_q.branch;
  assign EX_jump_o     = ctrl_q.jump;
endmodule
